// File: rtl/cache_flush_sequencer.sv
// Cache flush sequencer.
// Walks every cache line in set-major order (way inner). Dirty lines are
// written back and then invalidated. Valid clean lines are only invalidated.
// Invalid lines are skipped. Any command other than FLUSH_ALL is refused with
// a nack. All handshake and strobe outputs are registers; the index and tag
// outputs come straight from the walk counters and the latched tag.

module cache_flush_sequencer #(
    parameter int NSETS = 64,
    parameter int NWAYS = 4,
    parameter int TAG_W = 20,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4:0]               req_cmd,
    output logic                     resp_valid,
    output logic                     resp_nack,
    output logic                     busy,
    output logic                     meta_rd_en,
    output logic [$clog2(NSETS)-1:0] meta_rd_set,
    output logic [$clog2(NWAYS)-1:0] meta_rd_way,
    input  logic                     meta_rsp_valid,
    input  logic                     meta_rsp_dirty,
    input  logic [TAG_W-1:0]         meta_rsp_tag,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [$clog2(NSETS)-1:0] wb_set,
    output logic [$clog2(NWAYS)-1:0] wb_way,
    output logic [TAG_W-1:0]         wb_tag,
    output logic                     meta_wr_en,
    output logic [$clog2(NSETS)-1:0] meta_wr_set,
    output logic [$clog2(NWAYS)-1:0] meta_wr_way,
    output logic [CNT_W-1:0]         wb_count
);

    localparam int SW = $clog2(NSETS);
    localparam int WW = $clog2(NWAYS);

    localparam logic [4:0]    M_FLUSH_ALL = 5'b00101;
    localparam logic [SW-1:0] LAST_SET    = SW'(NSETS - 1);
    localparam logic [WW-1:0] LAST_WAY    = WW'(NWAYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        INVAL,
        NEXT,
        DONE
    } state_t;

    state_t            state;
    logic [SW-1:0]     set_idx;
    logic [WW-1:0]     way_idx;
    logic [TAG_W-1:0]  tag_q;
    logic              nack;

    // The walk counters never move while a line is being read, written back
    // or invalidated, so they can drive every index output directly and the
    // write-back fields stay stable for the whole handshake.
    assign meta_rd_set = set_idx;
    assign meta_rd_way = way_idx;
    assign wb_set      = set_idx;
    assign wb_way      = way_idx;
    assign wb_tag      = tag_q;
    assign meta_wr_set = set_idx;
    assign meta_wr_way = way_idx;

    // Walk controller: state, counters and every registered output move together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            set_idx    <= '0;
            way_idx    <= '0;
            tag_q      <= '0;
            nack       <= 1'b0;
            wb_count   <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_nack  <= 1'b0;
            meta_rd_en <= 1'b0;
            wb_valid   <= 1'b0;
            meta_wr_en <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_nack  <= 1'b0;
            meta_rd_en <= 1'b0;
            meta_wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_cmd == M_FLUSH_ALL) begin
                            set_idx    <= '0;
                            way_idx    <= '0;
                            wb_count   <= '0;
                            nack       <= 1'b0;
                            meta_rd_en <= 1'b1;
                            state      <= READ;
                        end else begin
                            nack       <= 1'b1;
                            resp_valid <= 1'b1;
                            resp_nack  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end

                READ: begin
                    state <= CHECK;
                end

                CHECK: begin
                    if (meta_rsp_valid && meta_rsp_dirty) begin
                        tag_q    <= meta_rsp_tag;
                        wb_valid <= 1'b1;
                        state    <= WB;
                    end else if (meta_rsp_valid) begin
                        meta_wr_en <= 1'b1;
                        state      <= INVAL;
                    end else begin
                        state <= NEXT;
                    end
                end

                WB: begin
                    if (wb_ready) begin
                        wb_valid   <= 1'b0;
                        meta_wr_en <= 1'b1;
                        if (wb_count != CNT_MAX) begin
                            wb_count <= wb_count + CNT_W'(1);
                        end
                        state <= INVAL;
                    end
                end

                INVAL: begin
                    state <= NEXT;
                end

                NEXT: begin
                    if (set_idx == LAST_SET && way_idx == LAST_WAY) begin
                        resp_valid <= 1'b1;
                        resp_nack  <= nack;
                        state      <= DONE;
                    end else begin
                        if (way_idx == LAST_WAY) begin
                            way_idx <= '0;
                            set_idx <= set_idx + SW'(1);
                        end else begin
                            way_idx <= way_idx + WW'(1);
                        end
                        meta_rd_en <= 1'b1;
                        state      <= READ;
                    end
                end

                DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    wb_valid  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // At most one of the metadata read, write-back and invalidate strobes is active.
    always @(posedge clock) begin
        if (!reset) begin
            assert ($countones({meta_rd_en, wb_valid, meta_wr_en}) <= 1)
                else $error("strobes not mutually exclusive");
        end
    end

    // The busy and ready registers always agree with the controller state.
    always @(posedge clock) begin
        if (!reset) begin
            assert (busy == (state != IDLE) && req_ready == (state == IDLE))
                else $error("busy/req_ready out of step with state");
        end
    end

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Self-checking bench for cache_flush_sequencer (4 sets x 2 ways, 2-bit counter).
// A metadata memory model answers reads and applies invalidates. The stimulus
// process computes the expected event stream for each command from the memory
// contents and pushes it into a scoreboard queue. A monitor pops and compares
// whenever the design presents a read, write-back, invalidate or response.

module tb_cache_flush_sequencer;

    localparam int NSETS   = 4;
    localparam int NWAYS   = 2;
    localparam int TAG_W   = 20;
    localparam int CNT_W   = 2;
    localparam int L       = NSETS * NWAYS;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [4:0] M_FLUSH_ALL = 5'b00101;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_cmd = 5'b0;
    logic             resp_valid;
    logic             resp_nack;
    logic             busy;
    logic             meta_rd_en;
    logic [1:0]       meta_rd_set;
    logic             meta_rd_way;
    logic             meta_rsp_valid = 1'b0;
    logic             meta_rsp_dirty = 1'b0;
    logic [TAG_W-1:0] meta_rsp_tag = '0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [1:0]       wb_set;
    logic             wb_way;
    logic [TAG_W-1:0] wb_tag;
    logic             meta_wr_en;
    logic [1:0]       meta_wr_set;
    logic             meta_wr_way;
    logic [CNT_W-1:0] wb_count;

    cache_flush_sequencer #(
        .NSETS(NSETS), .NWAYS(NWAYS), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .resp_valid(resp_valid), .resp_nack(resp_nack), .busy(busy),
        .meta_rd_en(meta_rd_en), .meta_rd_set(meta_rd_set), .meta_rd_way(meta_rd_way),
        .meta_rsp_valid(meta_rsp_valid), .meta_rsp_dirty(meta_rsp_dirty),
        .meta_rsp_tag(meta_rsp_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way),
        .wb_tag(wb_tag),
        .meta_wr_en(meta_wr_en), .meta_wr_set(meta_wr_set), .meta_wr_way(meta_wr_way),
        .wb_count(wb_count)
    );

    typedef enum int {EV_READ, EV_WB, EV_INVAL, EV_RESP} ev_kind_t;
    typedef struct {
        ev_kind_t         kind;
        int               set;
        int               way;
        logic [TAG_W-1:0] tag;
        int               lat;
        bit               nack;
        int               cnt;
    } ev_t;

    ev_t exp_q[$];
    int  stall_q[$];

    bit               mv [L];
    bit               md [L];
    logic [TAG_W-1:0] mt [L];

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int last_cnt = 0;
    bit accepted = 1'b0;
    bit resp_done = 1'b0;
    bit busy_exp = 1'b0;
    bit rd_prev = 1'b0;
    bit wb_active = 1'b0;
    int stall_left = 0;

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Compare the kind of event the design presents against the scoreboard head.
    task automatic matchFront(input ev_kind_t kind, output bit ok);
        tests++;
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: actual=%s required=none (cycle %0d)",
                     kind.name(), cyc);
        end else if (exp_q[0].kind != kind) begin
            errors++;
            $display("[TB] FAIL event_order: actual=%s required=%s (cycle %0d)",
                     kind.name(), exp_q[0].kind.name(), cyc);
        end else begin
            ok = 1'b1;
        end
    endtask

    // Memory responder followed by the scoreboard monitor, sampled on the falling edge.
    initial forever begin
        int idx;
        bit ok;
        @(negedge clock);
        if (reset) begin
            wb_active = 1'b0;
            wb_ready  = 1'b0;
            rd_prev   = 1'b0;
            busy_exp  = 1'b0;
        end else begin
            if (meta_rd_en) begin
                idx = int'(meta_rd_set) * NWAYS + int'(meta_rd_way);
                meta_rsp_valid = mv[idx];
                meta_rsp_dirty = md[idx];
                meta_rsp_tag   = mt[idx];
                rd_prev = 1'b1;
            end else if (rd_prev) begin
                rd_prev = 1'b0;
            end else begin
                meta_rsp_valid = 1'($urandom);
                meta_rsp_dirty = 1'($urandom);
                meta_rsp_tag   = TAG_W'($urandom);
            end
            if (meta_wr_en) begin
                idx = int'(meta_wr_set) * NWAYS + int'(meta_wr_way);
                mv[idx] = 1'b0;
                md[idx] = 1'b0;
            end
            if (wb_valid) begin
                if (!wb_active) begin
                    wb_active  = 1'b1;
                    stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                end
                if (stall_left > 0) begin
                    wb_ready = 1'b0;
                    stall_left--;
                end else begin
                    wb_ready = 1'b1;
                end
            end else begin
                wb_active = 1'b0;
                wb_ready  = 1'b0;
            end

            checkOutput("busy", longint'(busy), longint'(busy_exp));
            checkOutput("req_ready", longint'(req_ready), longint'(!busy_exp));
            if (meta_rd_en || wb_valid || meta_wr_en) begin
                checkOutput("strobe_exclusive",
                            longint'(int'(meta_rd_en) + int'(wb_valid) + int'(meta_wr_en)), 1);
            end
            if (meta_rd_en) begin
                matchFront(EV_READ, ok);
                if (ok) begin
                    checkOutput("rd_set", longint'(meta_rd_set), longint'(exp_q[0].set));
                    checkOutput("rd_way", longint'(meta_rd_way), longint'(exp_q[0].way));
                    void'(exp_q.pop_front());
                end
            end
            if (wb_valid) begin
                matchFront(EV_WB, ok);
                if (ok) begin
                    checkOutput("wb_set", longint'(wb_set), longint'(exp_q[0].set));
                    checkOutput("wb_way", longint'(wb_way), longint'(exp_q[0].way));
                    checkOutput("wb_tag", longint'(wb_tag), longint'(exp_q[0].tag));
                    if (wb_ready) void'(exp_q.pop_front());
                end
            end
            if (meta_wr_en) begin
                matchFront(EV_INVAL, ok);
                if (ok) begin
                    checkOutput("wr_set", longint'(meta_wr_set), longint'(exp_q[0].set));
                    checkOutput("wr_way", longint'(meta_wr_way), longint'(exp_q[0].way));
                    void'(exp_q.pop_front());
                end
            end
            if (resp_valid) begin
                matchFront(EV_RESP, ok);
                if (ok) begin
                    checkOutput("resp_nack", longint'(resp_nack), longint'(exp_q[0].nack));
                    checkOutput("resp_latency", longint'(cyc - accept_cyc), longint'(exp_q[0].lat));
                    checkOutput("wb_count", longint'(wb_count), longint'(exp_q[0].cnt));
                    void'(exp_q.pop_front());
                end
                busy_exp  = 1'b0;
                resp_done = 1'b1;
            end
            if (req_valid && req_ready) begin
                accepted   = 1'b1;
                accept_cyc = cyc;
                busy_exp   = 1'b1;
            end
        end
    end

    // Reference model: expected events, stalls and latency straight from the flush rules.
    task automatic buildExpect(input logic [4:0] cmd, input int kmin, input int kmax);
        ev_t e;
        int  lat;
        int  nd;
        if (cmd == M_FLUSH_ALL) begin
            lat = 3 * L + 1;
            nd  = 0;
            for (int s = 0; s < NSETS; s++) begin
                for (int w = 0; w < NWAYS; w++) begin
                    int i;
                    int k;
                    i = s * NWAYS + w;
                    e = '{EV_READ, s, w, '0, 0, 1'b0, 0};
                    exp_q.push_back(e);
                    if (mv[i] && md[i]) begin
                        k = int'($urandom_range(kmax, kmin));
                        stall_q.push_back(k);
                        e = '{EV_WB, s, w, mt[i], 0, 1'b0, 0};
                        exp_q.push_back(e);
                        e = '{EV_INVAL, s, w, '0, 0, 1'b0, 0};
                        exp_q.push_back(e);
                        lat += 2 + k;
                        nd++;
                    end else if (mv[i]) begin
                        e = '{EV_INVAL, s, w, '0, 0, 1'b0, 0};
                        exp_q.push_back(e);
                        lat += 1;
                    end
                end
            end
            last_cnt = (nd > CNT_MAX) ? CNT_MAX : nd;
            e = '{EV_RESP, 0, 0, '0, lat, 1'b0, last_cnt};
        end else begin
            e = '{EV_RESP, 0, 0, '0, 1, 1'b1, last_cnt};
        end
        exp_q.push_back(e);
    endtask

    task automatic clearMemory();
        for (int i = 0; i < L; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
    endtask

    task automatic randomMemory();
        for (int i = 0; i < L; i++) begin
            mv[i] = 1'($urandom);
            md[i] = 1'($urandom);
            mt[i] = TAG_W'($urandom);
        end
    endtask

    task automatic doReset();
        @(posedge clock); #1;
        reset = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        stall_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        last_cnt = 0;
    endtask

    // Issue one command, optionally keeping req_valid up while it runs.
    task automatic applyStimulus(input logic [4:0] cmd, input bit hold,
                                 input int kmin, input int kmax, input string name);
        buildExpect(cmd, kmin, kmax);
        @(posedge clock); #1;
        accepted  = 1'b0;
        resp_done = 1'b0;
        req_cmd   = cmd;
        req_valid = 1'b1;
        for (int n = 0; n < 3000 && !resp_done; n++) begin
            @(posedge clock); #1;
            if (accepted && !hold) req_valid = 1'b0;
            if (hold && resp_valid) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        if (!resp_done) begin
            tests++;
            errors++;
            $display("[TB] FAIL %s_timeout: actual=no response required=response", name);
            doReset();
        end
        checkOutput({name, "_drained"}, longint'(exp_q.size()), 0);
    endtask

    task automatic resetDuringWriteBack();
        bit seen;
        clearMemory();
        mv[5] = 1'b1;
        md[5] = 1'b1;
        mt[5] = 20'h0BEEF;
        buildExpect(M_FLUSH_ALL, 4, 4);
        @(posedge clock); #1;
        accepted  = 1'b0;
        resp_done = 1'b0;
        req_cmd   = M_FLUSH_ALL;
        req_valid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(posedge clock); #1;
            if (accepted) req_valid = 1'b0;
            if (wb_valid) seen = 1'b1;
        end
        req_valid = 1'b0;
        checkOutput("reset_wb_reached", longint'(seen), 1);
        reset = 1'b1;
        exp_q.delete();
        stall_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        last_cnt = 0;
        @(negedge clock);
        checkOutput("rst_wb_valid", longint'(wb_valid), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        checkOutput("rst_wb_count", longint'(wb_count), 0);
        checkOutput("rst_wb_set", longint'(wb_set), 0);
        checkOutput("rst_wb_way", longint'(wb_way), 0);
        checkOutput("rst_wb_tag", longint'(wb_tag), 0);
        for (int n = 0; n < 6; n++) begin
            checkOutput("rst_no_resp", longint'(resp_valid), 0);
            @(negedge clock);
        end
    endtask

    initial begin
        clearMemory();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("init_req_ready", longint'(req_ready), 1);
        checkOutput("init_busy", longint'(busy), 0);
        checkOutput("init_resp_valid", longint'(resp_valid), 0);
        checkOutput("init_resp_nack", longint'(resp_nack), 0);
        checkOutput("init_meta_rd_en", longint'(meta_rd_en), 0);
        checkOutput("init_wb_valid", longint'(wb_valid), 0);
        checkOutput("init_meta_wr_en", longint'(meta_wr_en), 0);
        checkOutput("init_wb_count", longint'(wb_count), 0);
        checkOutput("init_rd_index", longint'({meta_rd_set, meta_rd_way}), 0);
        checkOutput("init_wr_index", longint'({meta_wr_set, meta_wr_way}), 0);
        checkOutput("init_wb_tag", longint'(wb_tag), 0);

        applyStimulus(M_FLUSH_ALL, 1'b0, 0, 0, "empty_flush");

        clearMemory();
        mv[5] = 1'b1;
        md[5] = 1'b1;
        mt[5] = 20'h12345;
        applyStimulus(M_FLUSH_ALL, 1'b0, 3, 3, "dirty_flush");

        clearMemory();
        mv[2] = 1'b1;
        mt[2] = 20'h00777;
        applyStimulus(M_FLUSH_ALL, 1'b0, 0, 0, "clean_flush");

        applyStimulus(5'b00000, 1'b0, 0, 0, "nack_xrd");

        randomMemory();
        applyStimulus(M_FLUSH_ALL, 1'b1, 0, 2, "held_flush");

        for (int i = 0; i < L; i++) begin
            mv[i] = 1'b1;
            md[i] = 1'b1;
            mt[i] = TAG_W'(32'h100 + i);
        end
        applyStimulus(M_FLUSH_ALL, 1'b0, 0, 1, "saturate_flush");
        applyStimulus(5'b11111, 1'b1, 0, 0, "nack_held_count");

        resetDuringWriteBack();
        applyStimulus(M_FLUSH_ALL, 1'b0, 0, 2, "post_reset_flush");

        for (int t = 0; t < 12; t++) begin
            logic [4:0] cmd;
            randomMemory();
            if ($urandom_range(3, 0) == 0) begin
                cmd = 5'($urandom);
                if (cmd == M_FLUSH_ALL) cmd = 5'b00000;
            end else begin
                cmd = M_FLUSH_ALL;
            end
            applyStimulus(cmd, 1'($urandom), 0, 3, "random_cmd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
